// File: rtl/lutram_march_ctrl.sv
// March C- self-test sequencer for a single-port LUTRAM (sync write, async read).
// Issues one RAM op per clock, compares reads and records error count and first failure.
module lutram_march_ctrl #(
    parameter int A_WIDTH = 6,
    parameter int ERR_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               pass_o,
    output logic [ERR_W-1:0]   err_count_o,
    output logic [A_WIDTH-1:0] fail_addr_o,
    output logic [2:0]         fail_elem_o,
    output logic [A_WIDTH-1:0] ram_a_o,
    output logic               ram_d_o,
    output logic               ram_we_o,
    input  logic               ram_q_i
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [A_WIDTH-1:0] ADDR_ONE = A_WIDTH'(1);
    localparam logic [ERR_W-1:0]   ERR_ONE  = ERR_W'(1);

    logic [1:0]         state_q, state_d;
    logic [2:0]         elem_q, elem_d;
    logic               op_q, op_d;
    logic [A_WIDTH-1:0] addr_q, addr_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic [A_WIDTH-1:0] fail_addr_q, fail_addr_d;
    logic [2:0]         fail_elem_q, fail_elem_d;

    logic running, two_op, is_write, wr_val, rd_exp, down, last_op, last_addr, rd_err;

    // Element decode: 0 = w0, 1..4 = read then write, 5 = r0; 3 and 4 run downward.
    assign running   = (state_q == S_RUN);
    assign two_op    = (elem_q != 3'd0) && (elem_q != 3'd5);
    assign is_write  = two_op ? op_q : (elem_q == 3'd0);
    assign wr_val    = (elem_q == 3'd1) || (elem_q == 3'd3);
    assign rd_exp    = (elem_q == 3'd2) || (elem_q == 3'd4);
    assign down      = (elem_q == 3'd3) || (elem_q == 3'd4);
    assign last_op   = !two_op || op_q;
    assign last_addr = down ? (addr_q == '0) : (addr_q == '1);
    assign rd_err    = running && !is_write && (ram_q_i != rd_exp);

    assign busy_o      = running;
    assign done_o      = (state_q == S_DONE);
    assign pass_o      = done_o && (err_q == '0);
    assign err_count_o = err_q;
    assign fail_addr_o = fail_addr_q;
    assign fail_elem_o = fail_elem_q;
    assign ram_a_o     = addr_q;
    assign ram_we_o    = running && is_write;
    assign ram_d_o     = running && is_write && wr_val;

    always_comb begin
        state_d     = state_q;
        elem_d      = elem_q;
        op_d        = op_q;
        addr_d      = addr_q;
        err_d       = err_q;
        fail_addr_d = fail_addr_q;
        fail_elem_d = fail_elem_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d     = S_RUN;
                    elem_d      = '0;
                    op_d        = 1'b0;
                    addr_d      = '0;
                    err_d       = '0;
                    fail_addr_d = '0;
                    fail_elem_d = '0;
                end
            end
            S_RUN: begin
                // err_q only grows within a run, so zero means no earlier mismatch.
                if (rd_err) begin
                    if (err_q != '1) err_d = err_q + ERR_ONE;
                    if (err_q == '0) begin
                        fail_addr_d = addr_q;
                        fail_elem_d = elem_q;
                    end
                end
                if (!last_op) begin
                    op_d = 1'b1;
                end else begin
                    op_d = 1'b0;
                    if (!last_addr) begin
                        addr_d = down ? addr_q - ADDR_ONE : addr_q + ADDR_ONE;
                    end else if (elem_q == 3'd5) begin
                        state_d = S_DONE;
                        elem_d  = '0;
                        addr_d  = '0;
                    end else begin
                        elem_d = elem_q + 3'd1;
                        addr_d = ((elem_q == 3'd2) || (elem_q == 3'd3)) ? '1 : '0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            elem_q      <= '0;
            op_q        <= 1'b0;
            addr_q      <= '0;
            err_q       <= '0;
            fail_addr_q <= '0;
            fail_elem_q <= '0;
        end else begin
            state_q     <= state_d;
            elem_q      <= elem_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            err_q       <= err_d;
            fail_addr_q <= fail_addr_d;
            fail_elem_q <= fail_elem_d;
        end
    end

endmodule

// File: tb/tb_lutram_march_ctrl.sv
// Scoreboard bench for lutram_march_ctrl: a march reference model queues expected RAM ops
// and end-of-run results; a negedge monitor pops and compares them against the DUT.
module tb_lutram_march_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start;
    logic       busy, done, pass, rd, rwe, rq;
    logic [7:0] errc;
    logic [5:0] fa, ra;
    logic [2:0] fe;
    logic       busy4, done4, pass4, rd4, rwe4;
    logic [3:0] errc4;
    logic [5:0] fa4, ra4;
    logic [2:0] fe4;

    lutram_march_ctrl #(.A_WIDTH(6), .ERR_W(8)) dut (
        .clk(clk), .rst(rst), .start_i(start),
        .busy_o(busy), .done_o(done), .pass_o(pass),
        .err_count_o(errc), .fail_addr_o(fa), .fail_elem_o(fe),
        .ram_a_o(ra), .ram_d_o(rd), .ram_we_o(rwe), .ram_q_i(rq)
    );

    // Second instance with a narrow counter and read data tied low.
    lutram_march_ctrl #(.A_WIDTH(6), .ERR_W(4)) dut4 (
        .clk(clk), .rst(rst), .start_i(start),
        .busy_o(busy4), .done_o(done4), .pass_o(pass4),
        .err_count_o(errc4), .fail_addr_o(fa4), .fail_elem_o(fe4),
        .ram_a_o(ra4), .ram_d_o(rd4), .ram_we_o(rwe4), .ram_q_i(1'b0)
    );

    // Behavioural RAM with an optional stuck-at cell (ftype 1 = SA0, 2 = SA1).
    logic mem [64];
    int   ftype = 0;
    int   faddr = 0;

    always @(posedge clk) if (rwe) mem[ra] <= rd;

    always_comb begin
        rq = mem[ra];
        if (ftype == 1 && int'(ra) == faddr) rq = 1'b0;
        if (ftype == 2 && int'(ra) == faddr) rq = 1'b1;
    end

    typedef struct packed {
        logic [5:0] a;
        logic       we;
        logic       d;
    } op_t;

    typedef struct {
        int err;
        int faddr;
        int felem;
        int pass;
        int err4;
        int faddr4;
        int felem4;
    } res_t;

    op_t  exp_ops[$];
    res_t exp_res[$];
    int   checks = 0;
    int   errors = 0;

    // March C- as listed: ops per element, write flag and value per op slot.
    int nops [6]  = '{1, 2, 2, 2, 2, 1};
    int opw  [12] = '{1, 0,  0, 1,  0, 1,  0, 1,  0, 1,  0, 0};
    int opv  [12] = '{0, 0,  0, 1,  1, 0,  0, 1,  1, 0,  0, 0};

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_run(input int ft, input int fadr);
        int   mm [64];
        res_t r;
        op_t  o;
        int   a, w, v, got, errs, e4;
        errs = 0; e4 = 0;
        r.faddr = 0; r.felem = 0; r.faddr4 = 0; r.felem4 = 0;
        for (int i = 0; i < 64; i++) mm[i] = 0;
        for (int e = 0; e < 6; e++) begin
            for (int i = 0; i < 64; i++) begin
                a = (e == 3 || e == 4) ? 63 - i : i;
                for (int k = 0; k < nops[e]; k++) begin
                    w = opw[e*2+k];
                    v = opv[e*2+k];
                    o.a  = 6'(a);
                    o.we = (w != 0);
                    o.d  = (w != 0) && (v != 0);
                    exp_ops.push_back(o);
                    if (w != 0) begin
                        mm[a] = v;
                    end else begin
                        got = mm[a];
                        if (ft == 1 && a == fadr) got = 0;
                        if (ft == 2 && a == fadr) got = 1;
                        if (got != v) begin
                            if (errs == 0) begin r.faddr = a; r.felem = e; end
                            if (errs < 255) errs++;
                        end
                        if (v != 0) begin
                            if (e4 == 0) begin r.faddr4 = a; r.felem4 = e; end
                            if (e4 < 15) e4++;
                        end
                    end
                end
            end
        end
        r.err  = errs;
        r.pass = (errs == 0) ? 1 : 0;
        r.err4 = e4;
        exp_res.push_back(r);
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    int   busy_cnt  = 0;
    logic busy_prev = 1'b0;
    logic done_prev = 1'b0;
    op_t  mon_o;
    res_t mon_r;

    always @(negedge clk) begin
        if (busy) begin
            if (!busy_prev) busy_cnt = 0;
            busy_cnt++;
            if (exp_ops.size() == 0) begin
                check("op_queue_empty", 1, 0);
            end else begin
                mon_o = exp_ops.pop_front();
                check("ram_a", int'(ra), int'(mon_o.a));
                check("ram_we", int'(rwe), int'(mon_o.we));
                check("ram_d", int'(rd), int'(mon_o.d));
            end
        end else begin
            check("we_outside_run", int'(rwe), 0);
        end
        if (done && !done_prev) begin
            check("busy_len", busy_cnt, 640);
            check("done_after_busy", int'(busy_prev), 1);
            if (exp_res.size() == 0) begin
                check("res_queue_empty", 1, 0);
            end else begin
                mon_r = exp_res.pop_front();
                check("err_count", int'(errc), mon_r.err);
                check("fail_addr", int'(fa), mon_r.faddr);
                check("fail_elem", int'(fe), mon_r.felem);
                check("pass", int'(pass), mon_r.pass);
                check("done4", int'(done4), 1);
                check("err_count4", int'(errc4), mon_r.err4);
                check("fail_addr4", int'(fa4), mon_r.faddr4);
                check("fail_elem4", int'(fe4), mon_r.felem4);
                check("pass4", int'(pass4), 0);
            end
        end
        busy_prev = busy;
        done_prev = done;
    end

    task automatic start_run(input int ft, input int fadr, input bit hold);
        ftype = ft;
        faddr = fadr;
        push_run(ft, fadr);
        start = 1'b1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        check("busy_at_t1", int'(busy), 1);
        check("err_cleared", int'(errc), 0);
        check("fail_addr_cleared", int'(fa), 0);
        check("fail_elem_cleared", int'(fe), 0);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        if (!done) check("done_timeout", 0, 1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_pass"}, int'(pass), 0);
        check({tag, "_err"}, int'(errc), 0);
        check({tag, "_faddr"}, int'(fa), 0);
        check({tag, "_felem"}, int'(fe), 0);
        check({tag, "_ram_a"}, int'(ra), 0);
        check({tag, "_ram_we"}, int'(rwe), 0);
        check({tag, "_ram_d"}, int'(rd), 0);
        check({tag, "_busy4"}, int'(busy4), 0);
        check({tag, "_we4"}, int'(rwe4), 0);
    endtask

    initial begin
        int ft, fad, gap;
        rst = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        start_run(0, 0, 1'b0);
        wait_done();
        check("ff_pass", int'(pass), 1);

        start_run(1, 17, 1'b0);
        wait_done();
        check("sa0_err", int'(errc), 2);
        check("sa0_elem", int'(fe), 2);
        check("sa0_addr", int'(fa), 17);
        check("sa0_pass", int'(pass), 0);
        check("tied0_err4", int'(errc4), 15);
        check("tied0_elem4", int'(fe4), 2);
        check("tied0_addr4", int'(fa4), 0);

        start_run(0, 0, 1'b0);
        wait_done();
        check("rerun_pass", int'(pass), 1);

        start_run(2, 63, 1'b0);
        wait_done();
        check("sa1_err", int'(errc), 3);
        check("sa1_elem", int'(fe), 1);
        check("sa1_addr", int'(fa), 63);

        start_run(0, 0, 1'b1);
        wait_done();

        start_run(0, 0, 1'b0);
        repeat (299) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_ops.delete();
        exp_res.delete();
        check_zero("abort");
        @(posedge clk); #1;
        start_run(0, 0, 1'b0);
        wait_done();
        check("after_abort_pass", int'(pass), 1);

        for (int r = 0; r < 4; r++) begin
            ft  = int'($urandom_range(0, 2));
            fad = int'($urandom_range(0, 63));
            gap = int'($urandom_range(0, 5));
            repeat (gap) @(posedge clk);
            #1;
            start_run(ft, fad, 1'b0);
            wait_done();
        end

        repeat (3) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
